// File: rtl/fp32_div_io.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_div_io
//  Description : IEEE-754 binary32 divider (quotient = a / b) built around a
//                26-step restoring mantissa divider, round-to-nearest-even,
//                flush-to-zero for subnormals. The low quotient bits are also
//                driven out to user GPIO pads.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_div_io #(
    parameter int IO_BITS = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               busy,
    output logic               done,
    output logic [31:0]        result,
    output logic [IO_BITS-1:0] io_out,
    output logic [IO_BITS-1:0] io_oeb
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  c_LAST_STEP = 5'd25;

    state_t      r_state;
    state_t      w_state_next;

    logic [4:0]  r_cnt;
    logic [24:0] r_rem;          // partial remainder, always < 2 * divisor
    logic [23:0] r_divisor;
    logic [25:0] r_quot;         // 24 significand bits + guard + round
    logic [9:0]  r_exp;          // signed biased exponent before normalization
    logic        r_sign;
    logic        r_special;
    logic [31:0] r_special_val;
    logic [31:0] r_result;

    // ------------------------------------------------------------------
    // Operand classification (only meaningful while accepting a request)
    // ------------------------------------------------------------------
    logic        w_a_zero, w_a_inf, w_a_nan;
    logic        w_b_zero, w_b_inf, w_b_nan;
    logic        w_sign_in;
    logic        w_special_in;
    logic [31:0] w_special_val_in;

    // Classify operands and pick the special-case result, first match wins.
    always_comb begin
        w_a_zero  = (a[30:23] == 8'd0);
        w_b_zero  = (b[30:23] == 8'd0);
        w_a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        w_b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        w_a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        w_b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        w_sign_in = a[31] ^ b[31];

        w_special_in     = 1'b1;
        w_special_val_in = 32'd0;
        if (w_a_nan || w_b_nan) begin
            w_special_val_in = c_QNAN;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_special_val_in = c_QNAN;
        end else if (w_a_inf || w_b_zero) begin
            w_special_val_in = {w_sign_in, 8'hFF, 23'd0};
        end else if (w_b_inf || w_a_zero) begin
            w_special_val_in = {w_sign_in, 31'd0};
        end else begin
            w_special_in = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Restoring division step
    // ------------------------------------------------------------------
    logic        w_ge;
    logic [24:0] w_rem_sub;

    // Subtract the divisor when it fits; the comparison is the quotient bit.
    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_divisor});
        w_rem_sub = w_ge ? (r_rem - {1'b0, r_divisor}) : r_rem;
    end

    // ------------------------------------------------------------------
    // Normalize, round to nearest even, range check
    // ------------------------------------------------------------------
    logic        w_norm;         // quotient >= 1.0, no left shift required
    logic [22:0] w_frac_pre;
    logic        w_guard;
    logic        w_round;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_frac_sum;     // bit 23 is the carry into the exponent
    logic [9:0]  w_exp_fin;
    logic [31:0] w_round_result;

    // Build the final quotient word from the divider state.
    always_comb begin
        w_norm     = r_quot[25];
        w_frac_pre = w_norm ? r_quot[24:2] : r_quot[23:1];
        w_guard    = w_norm ? r_quot[1]    : r_quot[0];
        w_round    = w_norm ? r_quot[0]    : 1'b0;
        w_sticky   = |r_rem;
        w_round_up = w_guard & (w_round | w_sticky | w_frac_pre[0]);
        w_frac_sum = {1'b0, w_frac_pre} + {23'd0, w_round_up};
        w_exp_fin  = r_exp - {9'd0, ~w_norm} + {9'd0, w_frac_sum[23]};

        if (r_special) begin
            w_round_result = r_special_val;
        end else if ($signed(w_exp_fin) >= $signed(10'sd255)) begin
            w_round_result = {r_sign, 8'hFF, 23'd0};
        end else if ($signed(w_exp_fin) <= $signed(10'sd0)) begin
            w_round_result = {r_sign, 31'd0};
        end else begin
            w_round_result = {r_sign, w_exp_fin[7:0], w_frac_sum[22:0]};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                busy = 1'b1;
                if (r_cnt == c_LAST_STEP) begin
                    w_state_next = S_ROUND;
                end
            end
            S_ROUND: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands, iterate the divider, register the result.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt         <= 5'd0;
            r_rem         <= 25'd0;
            r_divisor     <= 24'd0;
            r_quot        <= 26'd0;
            r_exp         <= 10'd0;
            r_sign        <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= 32'd0;
            r_result      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt         <= 5'd0;
                        r_rem         <= {2'b01, a[22:0]};
                        r_divisor     <= {1'b1, b[22:0]};
                        r_quot        <= 26'd0;
                        r_exp         <= {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
                        r_sign        <= w_sign_in;
                        r_special     <= w_special_in;
                        r_special_val <= w_special_val_in;
                    end
                end
                S_DIVIDE: begin
                    r_cnt  <= r_cnt + 5'd1;
                    r_quot <= {r_quot[24:0], w_ge};
                    r_rem  <= w_rem_sub << 1;
                end
                S_ROUND: begin
                    r_result <= w_round_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign io_out = r_result[IO_BITS-1:0];
    assign io_oeb = '0;

endmodule
`default_nettype wire

// File: tb/tb_fp32_div_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp32_div_io
//  Description : Self-checking bench for fp32_div_io: directed corner cases,
//                handshake/reset scenarios and random operands compared
//                against an integer-arithmetic reference divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_div_io;

    localparam int IO_BITS = 8;

    logic               wb_clk_i;
    logic               wb_rst_i;
    logic               start;
    logic [31:0]        a;
    logic [31:0]        b;
    logic               busy;
    logic               done;
    logic [31:0]       result;
    logic [IO_BITS-1:0] io_out;
    logic [IO_BITS-1:0] io_oeb;

    int n_checks = 0;
    int n_pass   = 0;

    fp32_div_io #(.IO_BITS(IO_BITS)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference divider: exact integer quotient with a remainder test,
    // then round-to-nearest-even and range clamping.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        int     ex, ey, e;
        logic   s, xz, yz, xi, yi, xn, yn, g, st;
        longint ma, mb, num, q, sig;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        if (xn || yn)                 return 32'h7FC0_0000;
        if ((xz && yz) || (xi && yi)) return 32'h7FC0_0000;
        if (xi || yz)                 return {s, 8'hFF, 23'd0};
        if (yi || xz)                 return {s, 31'd0};
        ma  = longint'(x[22:0]) + (longint'(1) << 23);
        mb  = longint'(y[22:0]) + (longint'(1) << 23);
        num = ma << 25;
        q   = num / mb;
        st  = (num % mb) != 0;
        e   = ex - ey + 127;
        if (q >= (longint'(1) << 25)) begin
            sig = q >> 2;
            g   = q[1];
            st  = st | q[0];
        end else begin
            sig = q >> 1;
            g   = q[0];
            e   = e - 1;
        end
        if (g && (st || sig[0])) sig = sig + 1;
        if (sig == (longint'(1) << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], sig[22:0]};
    endfunction

    // Issue one request in the next cycle and check latency and outputs.
    // Returns on the negedge where done is seen high.
    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y);
        int          c;
        logic [31:0] exp_q;
        exp_q = ref_div(x, y);
        @(negedge wb_clk_i);
        a = x; b = y; start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        @(negedge wb_clk_i);
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        c = 0;
        while (!done && c < 60) begin
            @(negedge wb_clk_i);
            c++;
        end
        chk({tag, " latency"}, c + 1, 32'd28);
        chk({tag, " result"}, result, exp_q);
        chk({tag, " io_out"}, {24'd0, io_out}, {24'd0, exp_q[7:0]});
        chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        chk({tag, " io_oeb"}, {24'd0, io_oeb}, 32'd0);
    endtask

    initial begin
        int          n_done;
        logic [31:0] got_q;
        logic [31:0] ra, rb;

        wb_rst_i = 1'b1;
        start    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        #1;
        chk("rst busy",   {31'd0, busy}, 32'd0);
        chk("rst done",   {31'd0, done}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst io_out", {24'd0, io_out}, 32'd0);
        chk("rst io_oeb", {24'd0, io_oeb}, 32'd0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Directed cases
        do_op("m33_pi",   32'hC204_0000, 32'h4049_0FDB);
        chk("m33_pi lit", result, 32'hC128_114F);
        do_op("one_pi",   32'h3F80_0000, 32'h4049_0FDB);
        chk("one_pi lit", result, 32'h3EA2_F983);
        do_op("six_3",    32'h40C0_0000, 32'h4040_0000);
        chk("six_3 lit",  result, 32'h4000_0000);
        do_op("x_div0",   32'h3F80_0000, 32'h0000_0000);
        chk("x_div0 lit", result, 32'h7F80_0000);
        do_op("0_div0",   32'h0000_0000, 32'h0000_0000);
        chk("0_div0 lit", result, 32'h7FC0_0000);
        do_op("m1_inf",   32'hBF80_0000, 32'h7F80_0000);
        chk("m1_inf lit", result, 32'h8000_0000);
        do_op("nan_1",    32'h7FC0_0001, 32'h3F80_0000);
        chk("nan_1 lit",  result, 32'h7FC0_0000);
        do_op("inf_inf",  32'hFF80_0000, 32'h7F80_0000);
        do_op("inf_fin",  32'hFF80_0000, 32'h3F80_0000);
        do_op("ovf",      32'h7F7F_FFFF, 32'h3E80_0000);
        chk("ovf lit",    result, 32'h7F80_0000);
        do_op("flush",    32'h0080_0000, 32'h4000_0000);
        chk("flush lit",  result, 32'h0000_0000);
        do_op("rne",      32'h3F80_0000, 32'h3F80_0001);
        chk("rne lit",    result, 32'h3F7F_FFFE);
        do_op("subn_a",   32'h0000_1234, 32'h3F80_0000);

        // Start while busy must be ignored.
        @(negedge wb_clk_i);
        a = 32'h4120_0000; b = 32'h4040_0000; start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        a = 32'h3F80_0000; b = 32'h4100_0000; start = 1'b1;
        @(negedge wb_clk_i);
        start  = 1'b0;
        n_done = 0;
        got_q  = 32'd0;
        for (int i = 0; i < 40 && n_done == 0; i++) begin
            @(negedge wb_clk_i);
            if (done) begin
                n_done++;
                got_q = result;
            end
        end
        for (int i = 0; i < 35; i++) begin
            @(negedge wb_clk_i);
            if (done) n_done++;
        end
        chk("ignore done count", n_done, 32'd1);
        chk("ignore result", got_q, ref_div(32'h4120_0000, 32'h4040_0000));

        // Back-to-back: second request in the cycle right after done.
        do_op("b2b_1", 32'h4120_0000, 32'h40E0_0000);
        do_op("b2b_2", 32'hC2C8_0000, 32'h3DCC_CCCD);

        // Reset in the middle of an operation.
        @(negedge wb_clk_i);
        a = 32'h4049_0FDB; b = 32'h402D_F854; start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        repeat (10) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("abort busy",   {31'd0, busy}, 32'd0);
        chk("abort done",   {31'd0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort io_out", {24'd0, io_out}, 32'd0);
        chk("abort io_oeb", {24'd0, io_oeb}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge wb_clk_i);
            if (done) n_done++;
        end
        chk("abort no done", n_done, 32'd0);

        // Random operands, mostly normal with occasional special exponents.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            ra[30:23] = 8'($urandom_range(64, 190));
            rb[30:23] = 8'($urandom_range(64, 190));
            if ($urandom_range(0, 9) == 0) ra[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 9) == 0) rb[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 7) == 0) ra[30:23] = 8'($urandom_range(230, 254));
            if ($urandom_range(0, 7) == 0) rb[30:23] = 8'($urandom_range(1, 20));
            do_op("rand", ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp32_div_io.md
Name: fp32_div_io

Overview:
- User-project arithmetic block for the Caravel harness.
- Performs one IEEE-754 single-precision division per request, quotient = a / b, using a sequential mantissa divider.
- Firmware loads the operands and pulses start; the block returns the 32-bit quotient.
- result[7:0] is also driven onto user GPIO mprj_io[7:0], so a chip-level bench can check the low quotient byte on the pins.

Parameters:
- IO_BITS, 8, number of low quotient bits driven to io_out/io_oeb.

Ports:
- wb_clk_i  in  1  system clock; all state updates on rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  32  dividend, IEEE-754 binary32; sampled when start is accepted.
- b  in  32  divisor, IEEE-754 binary32; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  quotient; holds its value until the next done.
- io_out  out  IO_BITS  result[IO_BITS-1:0]; feeds mprj_io[7:0].
- io_oeb  out  IO_BITS  pad output-enable, active-low; constant 0 (pads driven as outputs).

Behaviour:
- Reset (async, wb_rst_i=1): state=IDLE; busy=0; done=0; result=0; io_out=0. Reset during an operation aborts it; no done is produced.
- FSM states IDLE -> DIVIDE -> ROUND -> DONE -> IDLE.
  - IDLE: start=1 latches a and b, computes the special-case flags, enters DIVIDE.
  - DIVIDE: exactly 26 cycles of restoring division, one quotient bit per cycle. The dividend mantissa is {1,frac_a} and the divisor mantissa is {1,frac_b}. This yields 24 significand bits, a guard bit and a round bit; the sticky bit is the OR of the nonzero final remainder.
  - ROUND: 1 cycle. Normalize: if the quotient MSB is 0, shift left by 1 and decrement the exponent. Round to nearest, ties to even. Then compute exponent = ea - eb + 127 (signed 10-bit arithmetic) and adjust by +1 on rounding carry-out.
  - DONE: result and io_out are registered; done=1 for this one cycle; busy=0 in this cycle; return to IDLE.
- Latency: done is high on the 28th rising edge after the edge that accepted start. Special-case operands take the same latency.
- start while not in IDLE is ignored. Back-to-back operation is allowed: start may be asserted in the cycle after done.
- Sign = sign_a XOR sign_b for every non-NaN result.
- Special cases, first match wins:
  - any NaN operand -> 0x7FC00000.
  - 0/0 or inf/inf -> 0x7FC00000.
  - inf/finite -> signed inf.
  - finite nonzero/0 -> signed inf.
  - finite/inf -> signed zero.
  - 0/nonzero -> signed zero.
- Subnormal inputs (exp=0) are treated as zero.
- Biased exponent >= 255 after rounding -> signed inf (0x7F800000 | sign).
- Biased exponent <= 0 -> signed zero; no subnormal outputs.
- io_oeb = all zeros at all times, including during reset.

Test Plan:
- Reset then idle: assert wb_rst_i mid-operation, e.g. 10 cycles after start. Required: busy=0, done=0, result=0x00000000, io_out=0x00 immediately, and no done pulse afterwards.
- a=0xC2040000 (-33.0), b=0x40490FDB (pi). Required: done on edge 28, result=0xC128114F, io_out=0x4F.
- a=0x3F800000 (1.0), b=0x40490FDB. Required: result=0x3EA2F983, io_out=0x83. Also a=0x40C00000 (6.0), b=0x40400000 (3.0) -> 0x40000000; checks exact division with no rounding.
- Specials:
  - 0x3F800000/0x00000000 -> 0x7F800000.
  - 0x00000000/0x00000000 -> 0x7FC00000.
  - 0xBF800000/0x7F800000 -> 0x80000000.
  - 0x7FC00001/0x3F800000 -> 0x7FC00000.
  - All four take 28-cycle latency.
- Range limits:
  - 0x7F7FFFFF/0x3E800000 (max/0.25) -> 0x7F800000 (overflow).
  - 0x00800000/0x40000000 (min normal/2) -> 0x00000000 (flush).
  - 0x3F800000/0x3F800001 -> 0x3F7FFFFE (round-to-nearest check).
- Handshake: pulse start again while busy -> ignored, with exactly one done and result from the first operands. Then assert start the cycle after done -> a second result with correct latency.
